// File: rtl/decode_writeback_seq.sv
// SEQ Y86-64 decode/writeback stage: derives register IDs from icode, reads
// valA/valB combinationally and commits valE/valM into the 15-entry regfile.
`timescale 1ns/1ps
module decode_writeback_seq #(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 15,
    parameter logic [3:0] RSP_ID = 4'h4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic             wb_en,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic             reg_fault,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_val
);

    localparam logic [3:0] RNONE = 4'hF;

    logic [WIDTH-1:0] regs [NREGS];
    logic             need_ra;
    logic             need_rb;
    logic             wr_en;

    always_comb begin
        srcA    = RNONE;
        srcB    = RNONE;
        dstE    = RNONE;
        dstM    = RNONE;
        need_ra = 1'b0;
        need_rb = 1'b0;
        case (icode)
            4'h2: begin
                srcA    = rA;
                dstE    = cnd ? rB : RNONE;
                need_ra = 1'b1;
                need_rb = 1'b1;
            end
            4'h3: begin
                dstE    = rB;
                need_rb = 1'b1;
            end
            4'h4: begin
                srcA    = rA;
                srcB    = rB;
                need_ra = 1'b1;
                need_rb = 1'b1;
            end
            4'h5: begin
                srcB    = rB;
                dstM    = rA;
                need_ra = 1'b1;
                need_rb = 1'b1;
            end
            4'h6: begin
                srcA    = rA;
                srcB    = rB;
                dstE    = rB;
                need_ra = 1'b1;
                need_rb = 1'b1;
            end
            4'h8: begin
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            4'h9: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            4'hA: begin
                srcA    = rA;
                srcB    = RSP_ID;
                dstE    = RSP_ID;
                need_ra = 1'b1;
            end
            4'hB: begin
                srcA    = RSP_ID;
                srcB    = RSP_ID;
                dstE    = RSP_ID;
                dstM    = rA;
                need_ra = 1'b1;
            end
            default: ;
        endcase
    end

    assign reg_fault = (need_ra && (rA == RNONE)) || (need_rb && (rB == RNONE));
    assign wr_en     = wb_en && !reg_fault;

    // Reads see pre-edge contents; RNONE (and anything past the file) reads as 0.
    assign valA    = (srcA < 4'(NREGS))    ? regs[srcA]    : '0;
    assign valB    = (srcB < 4'(NREGS))    ? regs[srcB]    : '0;
    assign dbg_val = (dbg_sel < 4'(NREGS)) ? regs[dbg_sel] : '0;

    // The M write follows the E write so popq %rsp keeps valM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NREGS; i++) begin
                if (dstE == 4'(i)) begin
                    regs[i] <= valE;
                end
                if (dstM == 4'(i)) begin
                    regs[i] <= valM;
                end
            end
        end
    end

endmodule

// File: doc/decode_writeback_seq.md
Name: decode_writeback_seq

Overview:
- Decode and writeback stage of the SEQ Y86-64 core. Sits directly downstream of fetch and consumes its icode/rA/rB outputs.
- Holds the 15-entry architectural register file. Source/destination register IDs are derived from icode, and valA/valB are read combinationally for execute.
- valE/valM are committed on the rising clock edge that ends the instruction.
- pc_update_seq shares the same clock edge.

Parameters:
- WIDTH, 64, datapath and register width.
- NREGS, 15, architectural registers (IDs 0x0–0xE; 0xF = RNONE).
- RSP_ID, 4, register ID of %rsp.

Ports:
- clk  in  1  system clock, rising edge active
- rst_n  in  1  asynchronous active-low reset
- icode  in  4  instruction code from fetch
- rA  in  4  register specifier A from fetch
- rB  in  4  register specifier B from fetch
- cnd  in  1  condition result from execute (gates cmovXX writeback)
- valE  in  WIDTH  ALU result from execute
- valM  in  WIDTH  load data from memory stage
- wb_en  in  1  commit enable; low while halted, on memory_error or on invalid_instr
- srcA  out  4  decoded source A ID
- srcB  out  4  decoded source B ID
- dstE  out  4  effective E destination ID (after cnd gating)
- dstM  out  4  M destination ID
- valA  out  WIDTH  regfile[srcA], or 0 if srcA=0xF
- valB  out  WIDTH  regfile[srcB], or 0 if srcB=0xF
- reg_fault  out  1  a required register specifier is 0xF
- dbg_sel  in  4  debug read index
- dbg_val  out  WIDTH  regfile[dbg_sel], or 0 if dbg_sel=0xF

Behaviour:
- Reset: rst_n low asynchronously clears all 15 registers to 0, independent of clk. While in reset, writes are blocked. After reset, valA=valB=dbg_val=0 for any IDs.
- Register decode (combinational):
  - srcA: rA for icode 2, 4, 6, A; RSP_ID for 9, B; else 0xF.
  - srcB: rB for 4, 5, 6; RSP_ID for 8, 9, A, B; else 0xF.
  - dstE: rB for 3 and 6, and for 2 only if cnd=1; RSP_ID for 8, 9, A, B; else 0xF.
  - dstM: rA for 5 and B; else 0xF.
  - icode 0, 1, 7 and invalid codes C–F: all four IDs are 0xF.
- reg_fault = 1 when any of the following register fields is 0xF:
  - rA for icode 2, 4, 5, 6, A, B;
  - rB for 2, 3, 4, 5, 6.
- Reads are combinational, zero latency. Within a cycle, reads return pre-edge contents (no write bypass); the SEQ core reads before it commits.
- Writeback on the rising edge of clk, when rst_n=1 and wb_en=1:
  - if dstE≠0xF, regfile[dstE] ← valE;
  - if dstM≠0xF, regfile[dstM] ← valM;
  - if dstE=dstM (popq %rsp), valM wins and valE is discarded.
- No write occurs when reg_fault=1 or wb_en=0. All registers hold.
- Reset asserted mid-cycle: the pending writeback is lost and registers go to 0 immediately. First write happens on the first rising edge after rst_n deasserts.
- Width: values are stored unmodified at WIDTH bits. No sign handling in this block.

Test Plan:
1. Reset, then irmovq (icode=3, rA=F, rB=2, valE=0x10), wb_en=1, one edge -> dbg_sel=2 gives 0x10; srcA=srcB=F; dstE=2; every other register reads 0.
2. After 1: OPq (icode=6, rA=2, rB=3), regfile[3]=0 -> valA=0x10, valB=0 before the edge. With valE=0x10 after the edge, regfile[3]=0x10.
3. cmovXX (icode=2, rA=2, rB=5, valE=0x10) with cnd=0 -> dstE=F and regfile[5] unchanged at 0. Repeat with cnd=1 -> regfile[5]=0x10.
4. popq %rsp (icode=B, rA=4), valE=0x108, valM=0xAA -> srcA=srcB=4, dstE=dstM=4; after the edge regfile[4]=0xAA.
5. rmmovq with rA=F (icode=4) -> reg_fault=1. With icode=3, valE=0x55, rB=1 and wb_en=0 -> regfile[1] unchanged.
6. Load regfile[7]=0x77, then pull rst_n low midway between edges -> dbg_val(7)=0 before the next edge. Edges while in reset produce no writes.
